fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the async FIFO write port among NREQ requesters in the wclk domain.
//  Grants one requester at a time for a burst of up to BURST beats, ending early on req_last.
//  Drives winc/wdata straight into the FIFO write side and never writes while wfull is high.
// PARAMETERS
//  DSIZE  8  FIFO data width in bits
//  NREQ   4  number of requesters (2..16)
//  BURST  4  maximum beats per grant (>=1)
// PORTS
//  wclk       in   1           write-domain clock (single clock for this block)
//  wrst       in   1           asynchronous, active-high reset
//  req_valid  in   NREQ        per-requester data valid
//  req_data   in   NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE]
//  req_last   in   NREQ        marks the final beat of a requester's burst
//  req_ready  out  NREQ        beat accepted this cycle; valid & ready = transfer
//  winc       out  1           FIFO write enable
//  wdata      out  DSIZE       FIFO write data
//  wfull      in   1           FIFO full flag, synchronous to wclk
//  grant      out  NREQ        one-hot current owner; all zero when IDLE
//  busy       out  1           1 while in GRANT
// BEHAVIOUR
//  - Registered state: fsm {IDLE, GRANT}, owner (clog2 NREQ), rr_ptr (clog2 NREQ),
//    beat_cnt (clog2(BURST)+1 bits).
//  - Reset: wrst high asynchronously forces fsm=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
//    All outputs read 0 while wrst is high and in the cycle after it is released.
//  - IDLE: if any req_valid is set, scan from rr_ptr upward mod NREQ; the first set bit wins.
//    Next edge: owner<=winner, beat_cnt<=0, fsm<=GRANT. No set bits: stay in IDLE.
//  - Arbitration latency: one cycle from req_valid to grant. No beat transfers while in IDLE.
//  - GRANT outputs are combinational from registered state and inputs (zero-latency datapath):
//      req_ready[i] = (i==owner) & ~wfull
//      winc         = req_valid[owner] & ~wfull
//      wdata        = req_data[owner]  (forced to 0 in IDLE)
//  - Beat accepted = winc. On each accepted beat beat_cnt increments.
//  - Release: an accepted beat with req_last[owner]=1, or with beat_cnt==BURST-1, ends the grant.
//    Next edge: fsm<=IDLE, rr_ptr<=(owner+1) mod NREQ, beat_cnt<=0.
//    This leaves a one-cycle bubble between grants.
//  - Grant is locked while in GRANT:
//    - owner dropping req_valid holds the grant with no transfer and no count;
//    - other requesters wait.
//  - wfull high in GRANT: winc=0 and req_ready=0, beat_cnt frozen, grant held.
//    Writing resumes on the first cycle wfull is low.
//  - wfull is already mutually exclusive with winc, so the FIFO never sees a write while full.
//  - Requester data must be held stable while its valid is high and ready is low.
//  - Reset mid-burst: outputs drop to 0 immediately. Beats not accepted are not written.
//    Arbitration restarts from requester 0.
//  - NREQ=1: always re-grants requester 0, still with the one-cycle bubble.
// TESTING
//  1. Reset, req_valid=4'b0001, 3 beats, last on beat 3, wfull=0
//     -> grant=0001 one cycle later; 3 consecutive winc; wdata matches; back to IDLE.
//  2. req_valid=4'b1111 held, req_last always 0, BURST=4
//     -> grants in order 0,1,2,3,0, each exactly 4 winc, one idle cycle between grants.
//  3. Owner 2 mid-burst, wfull=1 for 5 cycles
//     -> winc=0 and req_ready=0 for those 5 cycles; beat_cnt unchanged; same data written on resume.
//  4. Owner 1 drops req_valid for 3 cycles mid-burst while 0 and 3 request
//     -> grant stays 0010, no winc, burst completes before 3 is granted.
//  5. wrst pulsed during beat 2 of a 4-beat burst
//     -> outputs 0 asynchronously; after release, requester 0 wins first if valid.
//  6. Scoreboard: random valid/last/wfull traffic, 10k cycles
//     -> FIFO data stream equals per-requester order; grant is always one-hot or zero; never winc&wfull.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake plus FIFO write-side bundle.
// master = requesters/FIFO side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  wfull;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   modport master (
      output req_valid, req_data, req_last, wfull,
      input  req_ready, winc, wdata, grant, busy
   );
   modport slave (
      input  req_valid, req_data, req_last, wfull,
      output req_ready, winc, wdata, grant, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the async FIFO write port, bursts of up to BURST beats.
// Datapath is combinational from the registered owner; a one-cycle IDLE bubble separates grants.
module fifo_wr_arbiter #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4,
   parameter int BURST = 4
) (
   input logic               wclk,
   input logic               wrst,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST) + 1;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   logic [0:0]    fsm;
   logic [IW-1:0] owner;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] winner;
   logic [IW-1:0] idx;
   logic [IW:0]   sum;
   logic [CW-1:0] beat_cnt;
   logic          busy;
   logic          winc;
   logic          done;
   assign busy = fsm == GRANT;
   assign winc = busy & bus.req_valid[owner] & ~bus.wfull;
   assign done = winc & (bus.req_last[owner] | beat_cnt == CW'(BURST - 1));
   assign bus.busy      = busy;
   assign bus.winc      = winc;
   assign bus.wdata     = busy ? bus.req_data[owner*DSIZE +: DSIZE] : '0;
   assign bus.grant     = busy ? NREQ'(1) << owner : '0;
   assign bus.req_ready = bus.wfull ? '0 : bus.grant;
   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      winner = '0;
      sum    = '0;
      idx    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         idx = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
         if (bus.req_valid[idx]) winner = idx;
      end
   end
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         fsm      <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else if (fsm == IDLE) begin
         if (|bus.req_valid) begin
            owner    <= winner;
            beat_cnt <= '0;
            fsm      <= GRANT;
         end
      end else if (done) begin
         fsm      <= IDLE;
         rr_ptr   <= owner == IW'(NREQ - 1) ? '0 : owner + IW'(1);
         beat_cnt <= '0;
      end else if (winc) begin
         beat_cnt <= beat_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and a random scoreboard run.
module tb_fifo_wr_arbiter;
   localparam int DSIZE = 8;
   localparam int NREQ  = 4;
   localparam int BURST = 4;
   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        wfull;
      logic [3:0]  grant;
      logic [3:0]  ready;
      logic        winc;
      logic        busy;
      logic [7:0]  wdata;
   } vec_t;
   logic wclk = 1'b0;
   logic wrst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 wclk = ~wclk;
   fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();
   fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
      .wclk(wclk),
      .wrst(wrst),
      .bus (bus)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.wfull     = f;
   endtask
   task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
      @(posedge wclk);
      #1 drive(v, l, d, f);
      @(negedge wclk);
   endtask
   task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] r,
                          input logic w, input logic b, input logic [7:0] d);
      chk({tag, " grant"}, 32'(bus.grant), 32'(g));
      chk({tag, " ready"}, 32'(bus.req_ready), 32'(r));
      chk({tag, " winc"}, 32'(bus.winc), 32'(w));
      chk({tag, " busy"}, 32'(bus.busy), 32'(b));
      chk({tag, " wdata"}, 32'(bus.wdata), 32'(d));
   endtask
   task automatic chk_zero(input string tag);
      chk_out(tag, 4'b0, 4'b0, 1'b0, 1'b0, 8'h0);
   endtask
   task automatic do_reset();
      wrst = 1'b1;
      drive(4'b0, 4'b0, 32'h0, 1'b0);
      repeat (2) @(posedge wclk);
      @(negedge wclk);
      chk_zero("in reset");
      @(posedge wclk);
      #1 wrst = 1'b0;
      @(negedge wclk);
      chk_zero("after release");
   endtask
   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                               input logic f, input logic [3:0] g, input logic [3:0] r,
                               input logic w, input logic b, input logic [7:0] wd);
      vec_t x;
      x.valid = v; x.last = l; x.data = d; x.wfull = f;
      x.grant = g; x.ready = r; x.winc = w; x.busy = b; x.wdata = wd;
      return x;
   endfunction
   vec_t tbl[$];
   logic [7:0]  q[NREQ][$];
   logic        pend[NREQ];
   logic        plast[NREQ];
   logic [7:0]  pdat[NREQ];
   int          seq[NREQ];
   initial begin
      // single requester 3-beat burst, then owner 1 stalls by dropping valid while 0 and 3 wait
      tbl.push_back(mk(4'b0001, 4'b0000, 32'h000000A1, 0, 4'b0000, 4'b0000, 0, 0, 8'h00));
      tbl.push_back(mk(4'b0001, 4'b0000, 32'h000000A1, 0, 4'b0001, 4'b0001, 1, 1, 8'hA1));
      tbl.push_back(mk(4'b0001, 4'b0000, 32'h000000A2, 0, 4'b0001, 4'b0001, 1, 1, 8'hA2));
      tbl.push_back(mk(4'b0001, 4'b0001, 32'h000000A3, 0, 4'b0001, 4'b0001, 1, 1, 8'hA3));
      tbl.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 4'b0000, 0, 0, 8'h00));
      tbl.push_back(mk(4'b1011, 4'b0000, 32'h3F20B130, 0, 4'b0000, 4'b0000, 0, 0, 8'h00));
      tbl.push_back(mk(4'b1011, 4'b0000, 32'h3F20B130, 0, 4'b0010, 4'b0010, 1, 1, 8'hB1));
      tbl.push_back(mk(4'b1001, 4'b0000, 32'h3F20B230, 0, 4'b0010, 4'b0010, 0, 1, 8'hB2));
      tbl.push_back(mk(4'b1001, 4'b0000, 32'h3F20B230, 0, 4'b0010, 4'b0010, 0, 1, 8'hB2));
      tbl.push_back(mk(4'b1001, 4'b0000, 32'h3F20B230, 0, 4'b0010, 4'b0010, 0, 1, 8'hB2));
      tbl.push_back(mk(4'b1011, 4'b0000, 32'h3F20B230, 0, 4'b0010, 4'b0010, 1, 1, 8'hB2));
      tbl.push_back(mk(4'b1011, 4'b0000, 32'h3F20B330, 0, 4'b0010, 4'b0010, 1, 1, 8'hB3));
      tbl.push_back(mk(4'b1011, 4'b0000, 32'h3F20B430, 0, 4'b0010, 4'b0010, 1, 1, 8'hB4));
      tbl.push_back(mk(4'b1001, 4'b0000, 32'h3F20B430, 0, 4'b0000, 4'b0000, 0, 0, 8'h00));
      tbl.push_back(mk(4'b1001, 4'b0000, 32'h3F20B430, 0, 4'b1000, 4'b1000, 1, 1, 8'h3F));
      do_reset();
      foreach (tbl[i]) begin
         cyc(tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].wfull);
         chk_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].ready, tbl[i].winc, tbl[i].busy, tbl[i].wdata);
      end
      // all four request forever: 0,1,2,3,0 with exactly BURST beats and one bubble each
      do_reset();
      cyc(4'b1111, 4'b0000, 32'h33221100, 0);
      chk_zero("rr arb");
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < BURST; b++) begin
            cyc(4'b1111, 4'b0000, 32'h33221100, 0);
            chk_out($sformatf("rr g%0d b%0d", g, b), 4'(1 << (g % 4)), 4'(1 << (g % 4)), 1, 1, 8'(8'h11 * (g % 4)));
         end
         cyc(4'b1111, 4'b0000, 32'h33221100, 0);
         chk_zero($sformatf("rr bubble%0d", g));
      end
      // wfull stall mid-burst on owner 2: nothing counted, same beat written on resume
      do_reset();
      cyc(4'b0100, 4'b0000, 32'h00200000, 0);
      chk_zero("full arb");
      cyc(4'b0100, 4'b0000, 32'h00200000, 0);
      chk_out("full b0", 4'b0100, 4'b0100, 1, 1, 8'h20);
      for (int s = 0; s < 5; s++) begin
         cyc(4'b0100, 4'b0000, 32'h00210000, 1);
         chk_out($sformatf("full stall%0d", s), 4'b0100, 4'b0000, 0, 1, 8'h21);
      end
      for (int b = 1; b < BURST; b++) begin
         cyc(4'b0100, 4'b0000, 32'(32'h00200000 + (b << 16)), 0);
         chk_out($sformatf("full b%0d", b), 4'b0100, 4'b0100, 1, 1, 8'(8'h20 + b));
      end
      cyc(4'b0100, 4'b0000, 32'h00240000, 0);
      chk_zero("full end");
      // async reset during beat 2 of owner 3's burst; restart must favour requester 0
      do_reset();
      cyc(4'b1000, 4'b0000, 32'h4A000000, 0);
      chk_zero("rst arb");
      cyc(4'b1000, 4'b0000, 32'h4A000000, 0);
      chk_out("rst b0", 4'b1000, 4'b1000, 1, 1, 8'h4A);
      @(posedge wclk);
      #1 drive(4'b1000, 4'b0000, 32'h4B000000, 0);
      #1 chk_out("rst b1", 4'b1000, 4'b1000, 1, 1, 8'h4B);
      #1 wrst = 1'b1;
      #1 chk_zero("rst async");
      @(posedge wclk);
      #1 drive(4'b0000, 4'b0000, 32'h0, 0);
      @(negedge wclk);
      chk_zero("rst held");
      @(posedge wclk);
      #1 wrst = 1'b0;
      drive(4'b1001, 4'b0000, 32'h4C00000A, 0);
      @(negedge wclk);
      chk_zero("rst released");
      cyc(4'b1001, 4'b0000, 32'h4C00000A, 0);
      chk_out("rst regrant", 4'b0001, 4'b0001, 1, 1, 8'h0A);
      // random traffic against per-requester ordering scoreboard
      do_reset();
      begin
         logic [3:0]  v, l, prev_grant;
         logic [31:0] d;
         logic        f, exp_rel;
         int          beats, o;
         prev_grant = '0;
         exp_rel = 1'b0;
         beats = 0;
         for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; plast[i] = 1'b0; pdat[i] = '0; seq[i] = 0;
         end
         for (int n = 0; n < 10000; n++) begin
            @(posedge wclk);
            #1;
            v = '0; l = '0; d = '0;
            for (int i = 0; i < NREQ; i++) begin
               if (!pend[i] && $urandom_range(0, 3) != 0) begin
                  pend[i]  = 1'b1;
                  pdat[i]  = {2'(i), 6'(seq[i])};
                  plast[i] = $urandom_range(0, 3) == 0;
                  seq[i]++;
                  q[i].push_back(pdat[i]);
               end
               v[i] = pend[i] && $urandom_range(0, 7) != 0;
               l[i] = plast[i];
               d[i*8 +: 8] = pdat[i];
            end
            f = $urandom_range(0, 4) == 0;
            drive(v, l, d, f);
            @(negedge wclk);
            chk("sb onehot", 32'($onehot0(bus.grant)), 32'd1);
            chk("sb winc&wfull", 32'(bus.winc & bus.wfull), 32'd0);
            if (exp_rel) chk("sb release", 32'(bus.grant), 32'd0);
            if (prev_grant != 0 && bus.grant != 0) chk("sb locked", 32'(bus.grant), 32'(prev_grant));
            exp_rel = 1'b0;
            if (bus.grant == 0) beats = 0;
            if (bus.winc) begin
               o = -1;
               for (int i = 0; i < NREQ; i++) if (bus.grant[i]) o = i;
               chk("sb winc owner", 32'(o >= 0), 32'd1);
               if (o >= 0) begin
                  chk("sb ready", 32'(bus.req_ready), 32'(bus.grant));
                  chk("sb queue", 32'(q[o].size() > 0), 32'd1);
                  if (q[o].size() > 0) chk($sformatf("sb data r%0d", o), 32'(bus.wdata), 32'(q[o].pop_front()));
                  pend[o] = 1'b0;
                  beats++;
                  chk("sb burst len", 32'(beats <= BURST), 32'd1);
                  exp_rel = plast[o] || beats == BURST;
               end
            end
            prev_grant = bus.grant;
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
